// File: rtl/alu_sequencer.sv
// Program sequencer: fetches {opr,a,b} words from RAM, launches the ALU for each,
// waits for completion (with optional timeout) and writes results to RES_BASE+pc.
module alu_sequencer #(
  parameter int                  ADDR_W   = 8,
  parameter int                  DATA_W   = 16,
  parameter int                  OPR_W    = 4,
  parameter int                  TMO_W    = 8,
  parameter logic [ADDR_W-1:0]   RES_BASE = 8'h80
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           prog_len,
  input  logic [TMO_W-1:0]            maxclock,
  output logic                        ram_rd,
  output logic [ADDR_W-1:0]           ram_raddr,
  input  logic [OPR_W+2*DATA_W-1:0]   ram_rdata,
  output logic                        ram_wr,
  output logic [ADDR_W-1:0]           ram_waddr,
  output logic [DATA_W-1:0]           ram_wdata,
  output logic [OPR_W-1:0]            opr,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  output logic                        alu_start,
  input  logic                        alux_done,
  input  logic [DATA_W-1:0]           alu_result,
  output logic                        busy,
  output logic                        done,
  output logic                        tmo_err,
  output logic                        opr_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAITRD, S_ISSUE, S_EXEC, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   len_q;
  logic [TMO_W-1:0]    maxclk_q;
  logic [TMO_W-1:0]    cnt;
  logic                legal;
  logic                last_instr;
  logic                tmo_hit;

  function automatic logic opr_legal(input logic [OPR_W-1:0] op);
    case (op)
      OPR_W'(0), OPR_W'(1), OPR_W'(2), OPR_W'(3), OPR_W'(4),
      OPR_W'(6), OPR_W'(8), OPR_W'(9), OPR_W'(10): return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  assign legal      = opr_legal(opr);
  assign last_instr = (pc == len_q - ADDR_W'(1));
  // maxclock == 0 disables the timeout entirely
  assign tmo_hit    = (maxclk_q != '0) && (cnt == maxclk_q);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = (prog_len == '0) ? S_DONE : S_FETCH;
      S_FETCH:  state_nx = S_WAITRD;
      S_WAITRD: state_nx = S_ISSUE;
      S_ISSUE:  state_nx = legal ? S_EXEC : S_NEXT;
      S_EXEC: begin
        if (alux_done)    state_nx = S_WRITE;
        else if (tmo_hit) state_nx = S_NEXT;
      end
      S_WRITE:  state_nx = S_NEXT;
      S_NEXT:   state_nx = last_instr ? S_DONE : S_FETCH;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      len_q     <= '0;
      maxclk_q  <= '0;
      cnt       <= '0;
      opr       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      ram_wdata <= '0;
      tmo_err   <= 1'b0;
      opr_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= prog_len;
            maxclk_q <= maxclock;
            pc       <= '0;
            tmo_err  <= 1'b0;
            opr_err  <= 1'b0;
          end
        end
        S_WAITRD: {opr, alu_a, alu_b} <= ram_rdata;
        S_ISSUE: begin
          cnt <= '0;
          if (!legal) opr_err <= 1'b1;
        end
        S_EXEC: begin
          // completion takes priority over a timeout in the same cycle
          if (alux_done)    ram_wdata <= alu_result;
          else if (tmo_hit) tmo_err   <= 1'b1;
          else              cnt       <= cnt + TMO_W'(1);
        end
        S_NEXT: if (!last_instr) pc <= pc + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign ram_rd    = (state == S_FETCH);
  assign ram_raddr = pc;
  assign ram_wr    = (state == S_WRITE);
  assign ram_waddr = (state == S_WRITE) ? RES_BASE + pc : '0;
  assign alu_start = (state == S_ISSUE) && legal;
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: RAM and ALU behavioural models, expected
// issues/writes queued at program load and popped as the DUT produces them.
module tb_alu_sequencer;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int OPR_W  = 4;
  localparam int TMO_W  = 8;
  localparam int RDW    = OPR_W + 2*DATA_W;

  logic              clock = 1'b0;
  logic              reset, start;
  logic [ADDR_W-1:0] prog_len;
  logic [TMO_W-1:0]  maxclock;
  logic              ram_rd, ram_wr, alu_start, busy, done, tmo_err, opr_err;
  logic [ADDR_W-1:0] ram_raddr, ram_waddr;
  logic [RDW-1:0]    ram_rdata;
  logic [DATA_W-1:0] ram_wdata, alu_a, alu_b, alu_result;
  logic [OPR_W-1:0]  opr;
  logic              alux_done;

  alu_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .prog_len(prog_len), .maxclock(maxclock),
    .ram_rd(ram_rd), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_wr(ram_wr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .opr(opr), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alux_done(alux_done), .alu_result(alu_result),
    .busy(busy), .done(done), .tmo_err(tmo_err), .opr_err(opr_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int rd_cnt = 0, st_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, kick_cyc = 0;
  int rd_cyc[$], st_cyc[$];
  logic [ADDR_W-1:0] rd_addr[$];
  logic [RDW-1:0]    iss_q[$];
  logic [23:0]       wr_q[$];
  logic [RDW-1:0]    imem [256];
  int                dly  [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd6:    return a << 1;
      4'd8:    return ~a;
      4'd9:    return a >> 1;
      4'd10:   return a + 16'd1;
      default: return 16'd0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10};
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor, RAM read port and ALU model, all acting away from the active edge
  initial begin : models
    bit                rd_prev = 1'b0;
    logic [ADDR_W-1:0] addr_prev = '0;
    bit                pend = 1'b0;
    int                rem = 0;
    logic [15:0]       res = '0;
    ram_rdata  = '0;
    alux_done  = 1'b0;
    alu_result = '0;
    forever begin
      @(negedge clock);
      if (ram_rd) begin
        rd_cnt++;
        rd_cyc.push_back(cyc);
        rd_addr.push_back(ram_raddr);
      end
      if (alu_start) begin
        st_cnt++;
        st_cyc.push_back(cyc);
        if (iss_q.size() == 0) chk("issue_extra", 64'(iss_q.size()), 64'd1);
        else chk("issue_ops", 64'({opr, alu_a, alu_b}), 64'(iss_q.pop_front()));
      end
      if (ram_wr) begin
        wr_cnt++;
        if (wr_q.size() == 0) chk("write_extra", 64'(wr_q.size()), 64'd1);
        else chk("write_addr_data", 64'({ram_waddr, ram_wdata}), 64'(wr_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      // read data is valid only in the cycle after the strobe; garbage otherwise
      if (rd_prev) ram_rdata = imem[addr_prev];
      else         ram_rdata = RDW'({$urandom(), $urandom()});
      rd_prev   = ram_rd;
      addr_prev = ram_raddr;
      alux_done = 1'b0;
      if (alu_start) begin
        pend = (dly[ram_raddr] >= 1);
        rem  = dly[ram_raddr];
        res  = alu_ref(opr, alu_a, alu_b);
      end else if (pend) begin
        if (rem == 1) begin
          alux_done  = 1'b1;
          alu_result = res;
          pend       = 1'b0;
        end else rem--;
      end
    end
  end

  task automatic clear();
    rd_cyc.delete(); st_cyc.delete(); rd_addr.delete();
    iss_q.delete(); wr_q.delete();
    for (int i = 0; i < 256; i++) begin
      imem[i] = '0;
      dly[i]  = -1;
    end
  endtask

  // d = ALU cycles in EXEC before alux_done (-1 = never); mclk = maxclock of the run
  task automatic instr(input int idx, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int d, input int mclk);
    imem[idx] = {op, a, b};
    dly[idx]  = d;
    if (is_legal(op)) begin
      iss_q.push_back({op, a, b});
      if (d >= 1 && (mclk == 0 || d <= mclk + 1))
        wr_q.push_back({8'(8'h80 + idx), alu_ref(op, a, b)});
    end
  endtask

  task automatic kick(input int len, input int mclk);
    @(negedge clock);
    prog_len = ADDR_W'(len);
    maxclock = TMO_W'(mclk);
    start    = 1'b1;
    kick_cyc = cyc;
    @(negedge clock);
    start    = 1'b0;
    prog_len = '0;
    maxclock = '0;
  endtask

  task automatic run(input int len, input int mclk, input bit repulse);
    int base;
    base = done_cnt;
    kick(len, mclk);
    if (repulse) begin
      repeat (3) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == base; i++) @(negedge clock);
    if (done_cnt == base) chk("done_timeout", 64'(done_cnt - base), 64'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s_ctrl", tag),
        64'({busy, ram_rd, ram_wr, alu_start, done, tmo_err, opr_err, ram_raddr}), 64'd0);
    chk($sformatf("%s_data", tag),
        64'({ram_waddr, ram_wdata, opr, alu_a, alu_b}), 64'd0);
  endtask

  initial begin : main
    int d0, s0, w0, r0;
    reset = 1'b1; start = 1'b0; prog_len = '0; maxclock = '0;
    clear();
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;

    // single add: 5+3 -> RAM[0x80]
    clear();
    instr(0, 4'd0, 16'd5, 16'd3, 2, 0);
    d0 = done_cnt; s0 = st_cnt; w0 = wr_cnt;
    run(1, 0, 0);
    chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t1_starts", 64'(st_cnt - s0), 64'd1);
    chk("t1_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t1_errs", 64'({tmo_err, opr_err}), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);

    // three instructions, stray start while busy must be ignored
    clear();
    instr(0, 4'd1, 16'h1234, 16'h0034, 1, 0);
    instr(1, 4'd2, 16'hF0F0, 16'h3C3C, 3, 0);
    instr(2, 4'd3, 16'h0A00, 16'h00B0, 2, 0);
    d0 = done_cnt; s0 = st_cnt; w0 = wr_cnt;
    run(3, 0, 1);
    chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t2_starts", 64'(st_cnt - s0), 64'd3);
    chk("t2_writes", 64'(wr_cnt - w0), 64'd3);
    chk("t2_wr_pending", 64'(wr_q.size()), 64'd0);

    // timeout on pc0 with maxclock=4, pc1 still runs and is written
    clear();
    instr(0, 4'd3, 16'd7, 16'd9, -1, 4);
    instr(1, 4'd4, 16'hAAAA, 16'h0F0F, 1, 4);
    s0 = st_cnt; w0 = wr_cnt;
    run(2, 4, 0);
    chk("t3_tmo_err", 64'({tmo_err, opr_err}), 64'b10);
    chk("t3_starts", 64'(st_cnt - s0), 64'd2);
    chk("t3_writes", 64'(wr_cnt - w0), 64'd1);
    if (st_cyc.size() >= 1 && rd_cyc.size() >= 2)
      chk("t3_exec_span", 64'(rd_cyc[1] - st_cyc[0]), 64'd7);
    else chk("t3_trace_len", 64'(rd_cyc.size()), 64'd2);

    // illegal opcode at pc1: flagged, not launched, pc0/pc2 written
    clear();
    instr(0, 4'd0, 16'd100, 16'd23, 1, 0);
    instr(1, 4'd5, 16'd1, 16'd2, 1, 0);
    instr(2, 4'd9, 16'h8000, 16'd0, 2, 0);
    s0 = st_cnt; w0 = wr_cnt; r0 = rd_cnt;
    run(3, 0, 0);
    chk("t4_errs", 64'({tmo_err, opr_err}), 64'b01);
    chk("t4_starts", 64'(st_cnt - s0), 64'd2);
    chk("t4_writes", 64'(wr_cnt - w0), 64'd2);
    chk("t4_reads", 64'(rd_cnt - r0), 64'd3);

    // reset while waiting in EXEC aborts the program without a write
    clear();
    instr(0, 4'd1, 16'd9, 16'd4, -1, 0);
    w0 = wr_cnt;
    kick(1, 0);
    repeat (4) @(negedge clock);
    chk("t5_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("t5_abort");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("t5_no_write", 64'(wr_cnt - w0), 64'd0);
    clear();
    instr(0, 4'd2, 16'hF0F0, 16'h0FF0, 1, 0);
    w0 = wr_cnt;
    run(1, 0, 0);
    chk("t5_restart_addr", 64'(rd_addr.size() > 0 ? rd_addr[0] : 8'hFF), 64'd0);
    chk("t5_restart_write", 64'(wr_cnt - w0), 64'd1);

    // empty program: done pulse shortly after start, nothing read
    clear();
    d0 = done_cnt; r0 = rd_cnt;
    run(0, 3, 0);
    chk("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t6_reads", 64'(rd_cnt - r0), 64'd0);
    chk("t6_latency_ok", 64'((done_cyc - kick_cyc) >= 1 && (done_cyc - kick_cyc) <= 2), 64'd1);

    // completion exactly at cnt==maxclock wins over the timeout
    clear();
    instr(0, 4'd6, 16'h0123, 16'd0, 5, 4);
    w0 = wr_cnt;
    run(1, 4, 0);
    chk("t7_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t7_tmo_err", 64'(tmo_err), 64'd0);

    chk("issue_pending", 64'(iss_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
